// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the div32_16 divider slice.
//   DIV_N   : default divisor/quotient/remainder width (dividend is 2*DIV_N)
//   state_t : divider control states (IDLE / CALC / DONE)
// No ports (package).
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_N = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational step of restoring division: shift the next dividend bit
// into the partial remainder, compare against the divisor in N+1 bits and
// subtract when the trial value is not smaller.
// Ports:
//   rem_in  [N-1:0] : partial remainder before this step
//   bit_in          : next dividend bit (MSB first)
//   divisor [N-1:0] : divisor
//   rem_out [N-1:0] : partial remainder after this step
//   q_bit           : quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step
    import div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic [N-1:0] rem_in,
    input  logic         bit_in,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] rem_out,
    output logic         q_bit
);

    logic [N:0] trial;

    assign trial = {rem_in, bit_in};
    assign q_bit = (trial >= {1'b0, divisor});
    // When the subtraction happens the true difference is below the divisor,
    // so computing it in N bits loses nothing.
    assign rem_out = q_bit ? (trial[N-1:0] - divisor) : trial[N-1:0];

endmodule

// File: rtl/div32_16.sv
// -----------------------------------------------------------------------------
// div32_16
// Sequential unsigned 2N-by-N restoring divider, one quotient bit per cycle.
// Handshake: an operation is accepted on in_valid && in_ready (IDLE only);
// the result is held with out_valid until out_ready is seen.
// Divide-by-zero returns dz=1, quotient all ones, remainder = dividend low half.
// Optional macro DIV32_16_OVF_DETECT_EN: when defined, operands whose dividend
// high half is >= a non-zero divisor are flagged ovf=1 with quotient all ones
// and remainder 0, skipping the iteration. When undefined, ovf is always 0.
// Ports:
//   clk, rst_n (sync, active-low)
//   in_valid, in_ready, dividend[2N-1:0], divisor[N-1:0]
//   out_valid, out_ready, quotient[N-1:0], remainder[N-1:0], dz, ovf
// -----------------------------------------------------------------------------
module div32_16
    import div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           dz,
    output logic           ovf
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count;
    logic [N-1:0]  rem;
    logic [N-1:0]  quo;
    logic [N-1:0]  dvs;
    logic          dz_r;
    logic          ovf_r;

    logic          div_zero;
    logic          ovf_hit;
    logic [N-1:0]  step_rem;
    logic          step_q;

    assign div_zero = (divisor == '0);

`ifdef DIV32_16_OVF_DETECT_EN
    assign ovf_hit = !div_zero && (dividend[2*N-1:N] >= divisor);
`else
    assign ovf_hit = 1'b0;
`endif

    // quo doubles as the dividend-low shift register: its MSB is the next
    // dividend bit, and quotient bits enter at the LSB.
    div_step #(.N(N)) u_step (
        .rem_in  (rem),
        .bit_in  (quo[N-1]),
        .divisor (dvs),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = (div_zero || ovf_hit) ? DONE : CALC;
                end
            end
            CALC: begin
                if (count == CW'(N - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            dz_r  <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvs   <= divisor;
                        count <= '0;
                        dz_r  <= div_zero;
                        ovf_r <= ovf_hit;
                        if (div_zero) begin
                            quo <= '1;
                            rem <= dividend[N-1:0];
                        end else if (ovf_hit) begin
                            quo <= '1;
                            rem <= '0;
                        end else begin
                            quo <= dividend[N-1:0];
                            rem <= dividend[2*N-1:N];
                        end
                    end
                end
                CALC: begin
                    rem   <= step_rem;
                    quo   <= {quo[N-2:0], step_q};
                    count <= count + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign quotient  = quo;
    assign remainder = rem;
    assign dz        = dz_r;
    assign ovf       = ovf_r;

endmodule

// File: doc/div32_16.md
DIV32_16 -- requirements
Module: div32_16

Interface
REQ-001 SHALL have parameter N, default 16, meaning divisor/quotient/remainder width; dividend width is 2N.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 SHALL have port in_valid  input  1  dividend/divisor offered.
REQ-005 SHALL have port in_ready  output  1  block can accept an operation.
REQ-006 SHALL have port dividend  input  2N  unsigned dividend (product-width operand).
REQ-007 SHALL have port divisor  input  N  unsigned divisor.
REQ-008 SHALL have port out_valid  output  1  result held on outputs.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port quotient  output  N  unsigned quotient.
REQ-011 SHALL have port remainder  output  N  unsigned remainder.
REQ-012 SHALL have port dz  output  1  divide-by-zero flag, valid with out_valid.
REQ-013 SHALL have port ovf  output  1  quotient-overflow flag, valid with out_valid.

Function
REQ-014 SHALL implement states IDLE, CALC, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 SHALL accept an operation on an edge with in_valid && in_ready, latching both operands; inputs are ignored outside IDLE.
REQ-016 SHALL compute by restoring division, one quotient bit per CALC cycle, MSB first: partial remainder starts as dividend[2N-1:N], each cycle shifts in the next dividend bit, compares in N+1 bits, and subtracts when >= divisor.
REQ-017 SHALL run exactly N CALC cycles, so out_valid rises N+1 cycles after the accept edge.
REQ-018 SHALL, when divisor==0, skip CALC, go IDLE->DONE, and present dz=1, quotient all ones, remainder=dividend[N-1:0]; out_valid rises 1 cycle after accept.
REQ-019 SHALL hold quotient, remainder, dz and ovf stable while out_valid=1 && out_ready=0.
REQ-020 SHALL leave DONE for IDLE on an edge with out_ready=1; the next accept occurs no earlier than the following edge (one bubble cycle; no result/accept overlap).
REQ-021 SHALL satisfy dividend == quotient*divisor + remainder and remainder < divisor for every non-zero, non-overflowing operation.

Reset
REQ-022 SHALL, on an edge with rst_n=0, go to IDLE, abandon any operation in CALC or DONE, and clear the iteration counter.
REQ-023 SHALL reset out_valid=0, quotient=0, remainder=0, dz=0, ovf=0; in_ready=1 from the first edge after reset is released.

Configuration
REQ-024 SHALL honour macro DIV32_16_OVF_DETECT_EN.
REQ-025 With the macro defined, SHALL treat dividend[2N-1:N] >= divisor (divisor != 0) as overflow: skip CALC, go to DONE after 1 cycle, and present ovf=1, quotient all ones, remainder=0.
REQ-026 Without the macro, SHALL tie ovf to 0 and process overflowing operands normally; quotient and remainder for such operands are unspecified and not checked.
REQ-027 dz SHALL take priority over ovf when divisor==0.

Structure
REQ-028 SHALL place the state-enum typedef (IDLE/CALC/DONE) and the default width constant in shared package div_pkg.
REQ-029 SHALL place the one-bit restoring step (shift, N+1-bit compare/subtract, quotient bit out) in a combinational sub-module div_step; the FSM and counter stay in div32_16.

Verification
REQ-030 A bench SHALL apply dividend=0x0000_0006, divisor=0x0003 -> quotient=0x0002, remainder=0x0000, out_valid 17 cycles after accept.
REQ-031 A bench SHALL apply dividend=0x0012_21DC, divisor=0x00FF -> quotient=0x1234, remainder=0x0010.
REQ-032 A bench SHALL apply dividend=0xFFFE_0001, divisor=0xFFFF -> quotient=0xFFFF, remainder=0x0000, dz=0, ovf=0.
REQ-033 A bench SHALL apply dividend=0x0000_1234, divisor=0x0000 -> dz=1, quotient=0xFFFF, remainder=0x1234, out_valid 1 cycle after accept.
REQ-034 A bench SHALL apply dividend=0x0001_0000, divisor=0x0001 with the macro defined -> ovf=1, quotient=0xFFFF, remainder=0; it SHALL also hold out_ready=0 for 5 cycles and check outputs stay stable.
REQ-035 A bench SHALL drive rst_n=0 at CALC cycle 8, then issue 100/7 -> outputs cleared, in_ready=1, then quotient=14, remainder=2.
